// File: rtl/fir_err_monitor.sv
// Error-statistics collector for (approximate, accurate) FIR result pairs.
// Counts mismatches, accumulates signed error and |accurate|, tracks max |error| over a programmed run.
module fir_err_monitor #(
    parameter int DATA_W     = 32,
    parameter int ER_THRESH1 = 8,
    parameter int CNT_W      = 32,
    parameter int ACC_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  test_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] appr,
    input  logic [DATA_W-1:0] accu,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [CNT_W-1:0]  n_err0,
    output logic [CNT_W-1:0]  n_err1,
    output logic [ACC_W-1:0]  err_sum,
    output logic [DATA_W:0]   abs_err_max,
    output logic [ACC_W-1:0]  res_abs_sum,
    output logic              acc_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [DATA_W:0]   X_ONE    = (DATA_W + 1)'(1);
    localparam logic [DATA_W:0]   X_ZERO   = {(DATA_W + 1){1'b0}};
    localparam logic [ACC_W-1:0]  ACC_ZERO = {ACC_W{1'b0}};
    localparam logic [ACC_W-1:0]  ES_MAX   = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0]  ES_MIN   = {1'b1, {(ACC_W - 1){1'b0}}};
    localparam logic [ACC_W-1:0]  RS_MAX   = {ACC_W{1'b1}};

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;

    logic               s1_valid_q, s1_valid_d;
    logic [DATA_W:0]    s1_e_q, s1_e_d;
    logic [DATA_W:0]    s1_abs_e_q, s1_abs_e_d;
    logic [DATA_W:0]    s1_abs_accu_q, s1_abs_accu_d;
    logic               s1_ne0_q, s1_ne0_d;
    logic               s1_ne1_q, s1_ne1_d;

    logic [CNT_W-1:0]   n_err0_q, n_err0_d;
    logic [CNT_W-1:0]   n_err1_q, n_err1_d;
    logic [ACC_W-1:0]   err_sum_q, err_sum_d;
    logic [DATA_W:0]    abs_err_max_q, abs_err_max_d;
    logic [ACC_W-1:0]   res_abs_sum_q, res_abs_sum_d;
    logic               acc_ovf_q, acc_ovf_d;

    logic               transfer_s;
    logic               last_s;
    logic               clear_s;
    logic [DATA_W:0]    appr_x_s;
    logic [DATA_W:0]    accu_x_s;
    logic [DATA_W:0]    e_s;
    logic [ACC_W:0]     es_ext_s;
    logic               es_ovf_s;
    logic [ACC_W-1:0]   es_sat_s;
    logic [ACC_W:0]     rs_ext_s;
    logic               rs_ovf_s;
    logic [ACC_W-1:0]   rs_sat_s;

    // Run control: start handling, last-sample detection and drain-to-done sequencing.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        clear_s    = 1'b0;
        transfer_s = in_valid & in_ready_q;
        last_s     = transfer_s & ((sample_cnt_q + CNT_ONE) == len_q);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear_s = 1'b1;
                    len_d   = test_len;
                    if (test_len == CNT_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // S2 of the final pair happens on the edge where S1 empties.
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d     = (state_d == ST_DONE);
    end

    // Stage 1: widen by one bit so the difference and both magnitudes never overflow.
    always_comb begin
        appr_x_s      = {appr[DATA_W-1], appr};
        accu_x_s      = {accu[DATA_W-1], accu};
        e_s           = appr_x_s - accu_x_s;
        s1_valid_d    = transfer_s;
        s1_e_d        = s1_e_q;
        s1_abs_e_d    = s1_abs_e_q;
        s1_abs_accu_d = s1_abs_accu_q;
        s1_ne0_d      = s1_ne0_q;
        s1_ne1_d      = s1_ne1_q;
        sample_cnt_d  = sample_cnt_q;
        if (clear_s) begin
            sample_cnt_d = CNT_ZERO;
        end else if (transfer_s) begin
            sample_cnt_d  = sample_cnt_q + CNT_ONE;
            s1_e_d        = e_s;
            s1_abs_e_d    = e_s[DATA_W] ? (~e_s + X_ONE) : e_s;
            s1_abs_accu_d = accu_x_s[DATA_W] ? (~accu_x_s + X_ONE) : accu_x_s;
            s1_ne0_d      = (appr != accu);
            s1_ne1_d      = (appr[DATA_W-1:ER_THRESH1] != accu[DATA_W-1:ER_THRESH1]);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    // Stage 2: saturating accumulation of the statistics.
    always_comb begin
        es_ext_s = {err_sum_q[ACC_W-1], err_sum_q}
                 + {{(ACC_W - DATA_W){s1_e_q[DATA_W]}}, s1_e_q};
        es_ovf_s = es_ext_s[ACC_W] ^ es_ext_s[ACC_W-1];
        if (es_ovf_s) begin
            es_sat_s = es_ext_s[ACC_W] ? ES_MIN : ES_MAX;
        end else begin
            es_sat_s = es_ext_s[ACC_W-1:0];
        end
        rs_ext_s = {1'b0, res_abs_sum_q} + {{(ACC_W - DATA_W){1'b0}}, s1_abs_accu_q};
        rs_ovf_s = rs_ext_s[ACC_W];
        if (rs_ovf_s) begin
            rs_sat_s = RS_MAX;
        end else begin
            rs_sat_s = rs_ext_s[ACC_W-1:0];
        end

        n_err0_d      = n_err0_q;
        n_err1_d      = n_err1_q;
        err_sum_d     = err_sum_q;
        abs_err_max_d = abs_err_max_q;
        res_abs_sum_d = res_abs_sum_q;
        acc_ovf_d     = acc_ovf_q;
        if (clear_s) begin
            n_err0_d      = CNT_ZERO;
            n_err1_d      = CNT_ZERO;
            err_sum_d     = ACC_ZERO;
            abs_err_max_d = X_ZERO;
            res_abs_sum_d = ACC_ZERO;
            acc_ovf_d     = 1'b0;
        end else if (s1_valid_q) begin
            n_err0_d      = n_err0_q + (s1_ne0_q ? CNT_ONE : CNT_ZERO);
            n_err1_d      = n_err1_q + (s1_ne1_q ? CNT_ONE : CNT_ZERO);
            err_sum_d     = es_sat_s;
            res_abs_sum_d = rs_sat_s;
            acc_ovf_d     = acc_ovf_q | es_ovf_s | rs_ovf_s;
            if (s1_abs_e_q > abs_err_max_q) begin
                abs_err_max_d = s1_abs_e_q;
            end else begin
                abs_err_max_d = abs_err_max_q;
            end
        end else begin
            acc_ovf_d = acc_ovf_q;
        end
    end

    // State, pipeline and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            len_q         <= CNT_ZERO;
            sample_cnt_q  <= CNT_ZERO;
            s1_valid_q    <= 1'b0;
            s1_e_q        <= X_ZERO;
            s1_abs_e_q    <= X_ZERO;
            s1_abs_accu_q <= X_ZERO;
            s1_ne0_q      <= 1'b0;
            s1_ne1_q      <= 1'b0;
            n_err0_q      <= CNT_ZERO;
            n_err1_q      <= CNT_ZERO;
            err_sum_q     <= ACC_ZERO;
            abs_err_max_q <= X_ZERO;
            res_abs_sum_q <= ACC_ZERO;
            acc_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            len_q         <= len_d;
            sample_cnt_q  <= sample_cnt_d;
            s1_valid_q    <= s1_valid_d;
            s1_e_q        <= s1_e_d;
            s1_abs_e_q    <= s1_abs_e_d;
            s1_abs_accu_q <= s1_abs_accu_d;
            s1_ne0_q      <= s1_ne0_d;
            s1_ne1_q      <= s1_ne1_d;
            n_err0_q      <= n_err0_d;
            n_err1_q      <= n_err1_d;
            err_sum_q     <= err_sum_d;
            abs_err_max_q <= abs_err_max_d;
            res_abs_sum_q <= res_abs_sum_d;
            acc_ovf_q     <= acc_ovf_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_cnt  = sample_cnt_q;
    assign n_err0      = n_err0_q;
    assign n_err1      = n_err1_q;
    assign err_sum     = err_sum_q;
    assign abs_err_max = abs_err_max_q;
    assign res_abs_sum = res_abs_sum_q;
    assign acc_ovf     = acc_ovf_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Scoreboard bench for fir_err_monitor: a 64-bit accumulator instance plus a 34-bit one
// sharing stimulus, so that saturation is reachable in a short run.
module tb_fir_err_monitor;

    typedef struct packed {
        logic [31:0] cnt;
        logic [31:0] ne0;
        logic [31:0] ne1;
        logic [32:0] amax;
        logic [63:0] esum_w;
        logic [63:0] rsum_w;
        logic        ovf_w;
        logic [33:0] esum_n;
        logic [33:0] rsum_n;
        logic        ovf_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] test_len;
    logic        in_valid;
    logic [31:0] appr;
    logic [31:0] accu;

    logic        in_ready, busy, done, acc_ovf;
    logic [31:0] sample_cnt, n_err0, n_err1;
    logic [63:0] err_sum, res_abs_sum;
    logic [32:0] abs_err_max;

    logic        s_in_ready, s_busy, s_done, s_acc_ovf;
    logic [31:0] s_sample_cnt, s_n_err0, s_n_err1;
    logic [33:0] s_err_sum, s_res_abs_sum;
    logic [32:0] s_abs_err_max;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   stim_ap[$];
    int   stim_ac[$];
    exp_t exp_q[$];
    logic done_prev = 1'b0;

    fir_err_monitor #(.DATA_W(32), .ER_THRESH1(8), .CNT_W(32), .ACC_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .test_len(test_len),
        .in_valid(in_valid), .in_ready(in_ready), .appr(appr), .accu(accu),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .n_err0(n_err0),
        .n_err1(n_err1), .err_sum(err_sum), .abs_err_max(abs_err_max),
        .res_abs_sum(res_abs_sum), .acc_ovf(acc_ovf)
    );

    fir_err_monitor #(.DATA_W(32), .ER_THRESH1(8), .CNT_W(32), .ACC_W(34)) dut_n (
        .clk(clk), .rst(rst), .start(start), .test_len(test_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .appr(appr), .accu(accu),
        .busy(s_busy), .done(s_done), .sample_cnt(s_sample_cnt), .n_err0(s_n_err0),
        .n_err1(s_n_err1), .err_sum(s_err_sum), .abs_err_max(s_abs_err_max),
        .res_abs_sum(s_res_abs_sum), .acc_ovf(s_acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic signed [127:0] sat_s(input logic signed [127:0] v, input int w,
                                                  inout logic ovf);
        logic signed [127:0] one;
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        one = 128'sd1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (v > hi) begin
            ovf = 1'b1;
            return hi;
        end else if (v < lo) begin
            ovf = 1'b1;
            return lo;
        end
        return v;
    endfunction

    function automatic logic [127:0] sat_u(input logic [127:0] v, input int w, inout logic ovf);
        logic [127:0] lim;
        lim = (128'd1 << w) - 128'd1;
        if (v > lim) begin
            ovf = 1'b1;
            return lim;
        end
        return v;
    endfunction

    // Reference statistics for the pairs currently in stim_ap / stim_ac.
    function automatic exp_t model();
        exp_t r;
        logic signed [127:0] es_w, es_n, e, ea, ac;
        logic [127:0] rs_w, rs_n;
        logic ow, on;
        r = '0; es_w = '0; es_n = '0; rs_w = '0; rs_n = '0; ow = 1'b0; on = 1'b0;
        for (int i = 0; i < stim_ap.size(); i++) begin
            e  = longint'(stim_ap[i]) - longint'(stim_ac[i]);
            ea = (e < 0) ? -e : e;
            ac = stim_ac[i];
            if (ac < 0) ac = -ac;
            r.cnt = r.cnt + 32'd1;
            if (stim_ap[i] != stim_ac[i]) r.ne0 = r.ne0 + 32'd1;
            if ((stim_ap[i] >>> 8) != (stim_ac[i] >>> 8)) r.ne1 = r.ne1 + 32'd1;
            if (ea > $signed({95'd0, r.amax})) r.amax = ea[32:0];
            es_w = sat_s(es_w + e, 64, ow);
            es_n = sat_s(es_n + e, 34, on);
            rs_w = sat_u(rs_w + ac, 64, ow);
            rs_n = sat_u(rs_n + ac, 34, on);
        end
        r.esum_w = es_w[63:0]; r.rsum_w = rs_w[63:0]; r.ovf_w = ow;
        r.esum_n = es_n[33:0]; r.rsum_n = rs_n[33:0]; r.ovf_n = on;
        return r;
    endfunction

    // Monitor: on each rising done, pop the next expected result and compare both instances.
    always @(negedge clk) begin
        exp_t ex;
        if (!rst && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 128'd1, 128'd0);
            end else begin
                ex = exp_q.pop_front();
                chk("sample_cnt", sample_cnt, ex.cnt);
                chk("n_err0", n_err0, ex.ne0);
                chk("n_err1", n_err1, ex.ne1);
                chk("abs_err_max", abs_err_max, ex.amax);
                chk("err_sum", err_sum, ex.esum_w);
                chk("res_abs_sum", res_abs_sum, ex.rsum_w);
                chk("acc_ovf", acc_ovf, ex.ovf_w);
                chk("busy_at_done", busy, 1'b0);
                chk("n_done", s_done, 1'b1);
                chk("n_sample_cnt", s_sample_cnt, ex.cnt);
                chk("n_n_err0", s_n_err0, ex.ne0);
                chk("n_n_err1", s_n_err1, ex.ne1);
                chk("n_abs_err_max", s_abs_err_max, ex.amax);
                chk("n_err_sum", s_err_sum, ex.esum_n);
                chk("n_res_abs_sum", s_res_abs_sum, ex.rsum_n);
                chk("n_acc_ovf", s_acc_ovf, ex.ovf_n);
            end
        end
        done_prev = done;
    end

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, {s_in_ready, in_ready}, 2'b00);
        chk({tag, "_busy"}, {s_busy, busy}, 2'b00);
        chk({tag, "_done"}, {s_done, done}, 2'b00);
        chk({tag, "_cnts"}, {sample_cnt, n_err0, n_err1, s_sample_cnt}, 128'd0);
        chk({tag, "_sums"}, {err_sum, res_abs_sum}, 128'd0);
        chk({tag, "_max_ovf"}, {abs_err_max, acc_ovf, s_err_sum, s_res_abs_sum, s_acc_ovf}, 128'd0);
        chk({tag, "_n_misc"}, {s_n_err0, s_n_err1, s_abs_err_max}, 128'd0);
    endtask

    task automatic do_start(input int len);
        test_len = len;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic add_pair(input int a, input int b);
        stim_ap.push_back(a);
        stim_ac.push_back(b);
    endtask

    // gap_mode: 0 back-to-back, 1 alternate idle cycles, 2 random idle cycles.
    task automatic run_pairs(input int gap_mode, input bit mid_start);
        int  n, idx, guard;
        bit  gap, rdy;
        n = stim_ap.size();
        exp_q.push_back(model());
        do_start(n);
        if (n == 0) begin
            chk("len0_done", done, 1'b1);
            repeat (3) begin
                chk("len0_in_ready", in_ready, 1'b0);
                @(posedge clk); #1;
            end
        end else begin
            idx = 0;
            guard = 0;
            while (idx < n) begin
                if (guard >= 2000) begin
                    chk("transfer_timeout", idx, n);
                    break;
                end
                gap = (gap_mode == 1) ? ((guard % 2) == 1)
                    : (gap_mode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
                start    = mid_start && (guard == 3);
                test_len = 32'd99;
                in_valid = !gap;
                appr     = gap ? $urandom : stim_ap[idx];
                accu     = gap ? $urandom : stim_ac[idx];
                rdy      = in_ready;
                guard++;
                @(posedge clk); #1;
                if (in_valid && rdy) idx++;
            end
            start    = 1'b0;
            in_valid = 1'b0;
            chk("drain_in_ready", in_ready, 1'b0);
            chk("drain_done", done, 1'b0);
            @(posedge clk); #1;
            chk("drain_done2", done, 1'b0);
            @(posedge clk); #1;
            chk("done_latency", done, 1'b1);
        end
        repeat (2) @(posedge clk);
        #1;
        stim_ap.delete();
        stim_ac.delete();
    endtask

    initial begin
        int n, kind, a, d;
        rst = 1'b1; start = 1'b1; test_len = 32'd5; in_valid = 1'b0; appr = '0; accu = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check_zero("post_reset");

        run_pairs(0, 1'b0);

        add_pair(10, 10); add_pair(10, 12); add_pair(-5, 3); add_pair(300, 44);
        run_pairs(0, 1'b0);
        add_pair(10, 10); add_pair(10, 12); add_pair(-5, 3); add_pair(300, 44);
        run_pairs(1, 1'b1);

        add_pair(32'h7FFF_FFFF, 32'h8000_0000); add_pair(0, 32'h8000_0000);
        run_pairs(0, 1'b0);

        do_start(5);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; appr = 32'd100 + i; accu = 32'd3;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("midrun_reset");
        add_pair(7, 7);
        run_pairs(0, 1'b0);

        for (int i = 0; i < 8; i++) add_pair(32'h7FFF_FFFF, 32'h8000_0000);
        run_pairs(2, 1'b0);
        for (int i = 0; i < 4; i++) add_pair(32'h8000_0000, 32'h7FFF_FFFF);
        run_pairs(0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                kind = $urandom_range(0, 2);
                a = $urandom;
                if (kind == 0) begin
                    a = $urandom_range(0, 2000) - 1000;
                    d = $urandom_range(0, 2000) - 1000;
                end else if (kind == 1) begin
                    d = a + ($urandom_range(0, 600) - 300);
                end else begin
                    d = $urandom;
                end
                add_pair(a, d);
            end
            run_pairs(2, r[0]);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) chk("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
